// File: rtl/moore4_pkg.sv
// Shared encodings and helpers for the four-state follower driver.
// Holds the follower state codes, the per-state hold codes, and the shortest-path hop table.
package moore4_pkg;

    typedef enum logic [1:0] {
        ST_A = 2'b00,
        ST_B = 2'b01,
        ST_C = 2'b10,
        ST_D = 2'b11
    } fstate_t;

    typedef enum logic {
        CTL_IDLE  = 1'b0,
        CTL_STEER = 1'b1
    } ctl_state_t;

    typedef struct packed {
        logic x;
        logic z;
    } xz_t;

    localparam xz_t HOLD_A = 2'b10;
    localparam xz_t HOLD_B = 2'b00;
    localparam xz_t HOLD_C = 2'b00;
    localparam xz_t HOLD_D = 2'b01;

    localparam int unsigned Y_LAG_MAX = 1;

    // Input code that keeps the follower parked in its current state.
    function automatic xz_t hold_code(input fstate_t s);
        hold_code = HOLD_A;
        case (s)
            ST_A: hold_code = HOLD_A;
            ST_B: hold_code = HOLD_B;
            ST_C: hold_code = HOLD_C;
            ST_D: hold_code = HOLD_D;
        endcase
    endfunction

    // First hop of the shortest route from s toward tgt (s != tgt).
    function automatic xz_t hop_code(input fstate_t s, input fstate_t tgt);
        hop_code = 2'b00;
        case (s)
            ST_A: hop_code = 2'b00;
            ST_B: hop_code = 2'b01;
            ST_C: hop_code = (tgt == ST_D) ? xz_t'(2'b01) : xz_t'(2'b10);
            ST_D: hop_code = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/moore4_step.sv
// Combinational next-state and output function of the follower Moore machine.
module moore4_step
    import moore4_pkg::*;
(
    input  logic [1:0] i_state,
    input  logic       i_x,
    input  logic       i_z,
    output logic [1:0] o_next,
    output logic       o_y
);

    fstate_t    w_state;
    fstate_t    w_next;
    logic [1:0] w_xz;

    always_comb begin
        w_state = fstate_t'(i_state);
        w_xz    = {i_x, i_z};
        w_next  = w_state;
        case (w_state)
            ST_A: w_next = (w_xz == 2'b10) ? ST_A : ST_B;
            ST_B: w_next = (w_xz == 2'b00) ? ST_B : ST_C;
            ST_C: begin
                if (w_xz == 2'b00)      w_next = ST_C;
                else if (w_xz == 2'b01) w_next = ST_D;
                else                    w_next = ST_A;
            end
            ST_D: w_next = (w_xz == 2'b01) ? ST_D : ST_C;
        endcase
    end

    assign o_next = w_next;
    assign o_y    = (w_state == ST_C);

endmodule

// File: rtl/moore4_driver.sv
// Steers an external four-state follower FSM to a commanded state via its x/z inputs.
// Optional y-output consistency checker enabled by defining MOORE4_CHECK_EN.
module moore4_driver
    import moore4_pkg::*;
#(
    parameter int unsigned Y_LAG = 1,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_state,
    output logic             cmd_ready,
    output logic             x,
    output logic             z,
    input  logic             y,
    output logic [1:0]       cur_state,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned LAG = (Y_LAG > Y_LAG_MAX) ? Y_LAG_MAX : Y_LAG;

    ctl_state_t r_state;
    ctl_state_t w_state_next;
    fstate_t    r_cur;
    fstate_t    r_tgt;
    fstate_t    w_tgt_next;
    fstate_t    w_cur_next;
    xz_t        r_xz;
    xz_t        w_xz_next;
    logic       r_done;
    logic       w_done_next;
    logic [1:0] w_step_next;
    logic       w_step_y;

    // Model of the follower, advanced by the x/z currently being driven.
    moore4_step u_step (
        .i_state (r_cur),
        .i_x     (r_xz.x),
        .i_z     (r_xz.z),
        .o_next  (w_step_next),
        .o_y     (w_step_y)
    );

    assign w_cur_next = fstate_t'(w_step_next);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= CTL_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // x/z are computed from the model's next state so they always match the state they drive.
    always_comb begin
        w_state_next = r_state;
        w_tgt_next   = r_tgt;
        w_done_next  = 1'b0;
        w_xz_next    = hold_code(w_cur_next);
        case (r_state)
            CTL_IDLE: begin
                if (cmd_valid) begin
                    w_state_next = CTL_STEER;
                    w_tgt_next   = fstate_t'(cmd_state);
                end
            end
            CTL_STEER: begin
                if (r_cur == r_tgt) begin
                    w_state_next = CTL_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = CTL_IDLE;
        endcase
        if ((w_state_next == CTL_STEER) && (w_cur_next != w_tgt_next)) begin
            w_xz_next = hop_code(w_cur_next, w_tgt_next);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cur  <= ST_A;
            r_tgt  <= ST_A;
            r_xz   <= HOLD_A;
            r_done <= 1'b0;
        end else begin
            r_cur  <= w_cur_next;
            r_tgt  <= w_tgt_next;
            r_xz   <= w_xz_next;
            r_done <= w_done_next;
        end
    end

    assign cmd_ready = (r_state == CTL_IDLE);
    assign busy      = (r_state == CTL_STEER);
    assign x         = r_xz.x;
    assign z         = r_xz.z;
    assign cur_state = r_cur;
    assign done      = r_done;

`ifdef MOORE4_CHECK_EN
    logic             r_y_d1;
    logic [1:0]       r_age;
    logic             r_mismatch;
    logic [ERR_W-1:0] r_err;
    logic             w_y_exp;
    logic             w_chk_on;
    logic             w_chk_fail;

    // Expected y is the model's y delayed by the follower's output lag.
    assign w_y_exp    = (LAG == 0) ? w_step_y : r_y_d1;
    assign w_chk_on   = (32'(r_age) >= LAG);
    assign w_chk_fail = w_chk_on && (y != w_y_exp);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_y_d1     <= 1'b0;
            r_age      <= 2'd0;
            r_mismatch <= 1'b0;
            r_err      <= '0;
        end else begin
            r_y_d1 <= w_step_y;
            if (r_age != 2'b11) begin
                r_age <= r_age + 2'd1;
            end
            if (w_chk_fail) begin
                r_mismatch <= 1'b1;
                if (r_err != {ERR_W{1'b1}}) begin
                    r_err <= r_err + ERR_W'(1);
                end
            end
        end
    end

    assign mismatch = r_mismatch;
    assign err_cnt  = r_err;
`else
    logic [2:0] w_unused_cfg;

    assign w_unused_cfg = {y, w_step_y, 1'(LAG)};
    assign mismatch     = 1'b0;
    assign err_cnt      = '0;
`endif

endmodule

// File: doc/moore4_driver.md
MOORE4_DRIVER -- requirements
Module: moore4_driver

Interface
REQ-001 The block SHALL have parameter Y_LAG, default 1, giving the cycles between the follower's state and its y output (legal values 0 or 1).
REQ-002 The block SHALL have parameter ERR_W, default 8, giving the width of err_cnt.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit, which requests steering to cmd_state.
REQ-006 The block SHALL have port cmd_state, input, 2 bits, the target follower state (A=00, B=01, C=10, D=11).
REQ-007 The block SHALL have port cmd_ready, output, 1 bit, which is high when a command can be accepted.
REQ-008 The block SHALL have ports x and z, outputs, 1 bit each, which drive the follower FSM inputs (registered).
REQ-009 The block SHALL have port y, input, 1 bit, the follower FSM output.
REQ-010 The block SHALL have port cur_state, output, 2 bits, the model of the follower state.
REQ-011 The block SHALL have ports busy and done, outputs, 1 bit each; done is a one-cycle pulse.
REQ-012 The block SHALL have port mismatch (output, 1 bit, sticky) and port err_cnt (output, ERR_W bits).

Function
REQ-013 The follower step SHALL be:
- A: xz=10 stays A; anything else goes to B.
- B: xz=00 stays B; anything else goes to C.
- C: 00 stays C; 01 goes to D; 10 or 11 go to A.
- D: 01 stays D; anything else goes to C.
- y is 1 only in C.
REQ-014 Each edge, cur_state SHALL advance by the step function applied to the x,z registered on the previous edge.
REQ-015 The control FSM SHALL have states IDLE and STEER; cmd_ready = (state==IDLE); busy = (state==STEER).
REQ-016 A command is accepted on an edge with cmd_valid&&cmd_ready; the target is latched and the FSM enters STEER.
REQ-017 In STEER, x,z SHALL be driven with the next hop of the shortest path:
- from A: 00
- from B: 01
- from C: 01 if the target is D, else 10
- from D: 00
REQ-018 In IDLE, and when cur_state equals the target, x,z SHALL be the hold code for cur_state: A 10, B 00, C 00, D 01.
REQ-019 When cur_state equals the latched target in STEER, done SHALL pulse for one cycle and the FSM SHALL return to IDLE; cmd_ready rises in the same cycle.
REQ-020 Path length SHALL be at most 3 steps; done SHALL occur 1 + path-length cycles after acceptance.
REQ-021 A target equal to cur_state at acceptance SHALL give done one cycle after acceptance, with no state movement.
REQ-022 cmd_valid while busy SHALL be ignored; no queueing.

Reset
REQ-023 While rst==0, outputs SHALL be: cur_state=A, x=1, z=0, FSM=IDLE, cmd_ready=1, busy=0, done=0, mismatch=0, err_cnt=0.
REQ-024 Reset during STEER SHALL abort the command with no done pulse.
REQ-025 Reset deassertion SHALL take effect on the first rising clk edge after rst goes high.

Configuration
REQ-026 With MOORE4_CHECK_EN defined, each cycle y SHALL be compared with (model state Y_LAG cycles earlier == C). The check starts Y_LAG+1 cycles after reset release.
REQ-027 On a check failure, mismatch SHALL set and hold until reset, and err_cnt SHALL increment, saturating at all-ones.
REQ-028 Without MOORE4_CHECK_EN, mismatch and err_cnt SHALL be tied to 0 and y SHALL be unused.

Structure
REQ-029 Package moore4_pkg SHALL hold the state encodings A..D, the hold-code constants, and the Y_LAG legal-range constant.
REQ-030 The step function SHALL be the combinational sub-module moore4_step (inputs: state, x, z; outputs: next state, y), so a bench can reuse it.

Verification
REQ-031 Reset release, then cmd_state=D: xz SHALL be 00, 01, 01 over consecutive cycles, cur_state SHALL go A→B→C→D, and done SHALL pulse at cycle 4.
REQ-032 With cur_state=D, cmd_state=B: path D→C→A→B, xz 00, 10, 00, then hold 00, and done SHALL pulse once.
REQ-033 With cur_state=C, cmd_state=C: done SHALL pulse the next cycle and xz SHALL stay 00.
REQ-034 cmd_valid held through a busy period: exactly one acceptance, and the second command SHALL be accepted only after done.
REQ-035 Reset asserted mid-STEER: no done pulse, cur_state=A, and xz=10 immediately.
REQ-036 With MOORE4_CHECK_EN and Y_LAG=1, force y=0 while the model is in C for 2 cycles: mismatch=1 and err_cnt=2.
